// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks in-flight register writers in EX and MEM,
// stalls ID consumers on read-after-write hazards, flushes on taken
// branches and drains the pipeline after HALT.
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_wr,
    input  logic [2:0]  id_dst,
    input  logic        id_halt,
    input  logic        ex_branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_stall,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] drain_cnt;

    // In-flight writers; WB is not tracked since the register file
    // writes before it reads.
    logic       ex_v;
    logic [2:0] ex_dst;
    logic       mem_v;
    logic [2:0] mem_dst;

    logic haz;
    logic issue;

    // A source register matches if either tracked writer targets it.
    function automatic logic match(input logic [2:0] r,
                                   input logic       ev, input logic [2:0] ed,
                                   input logic       mv, input logic [2:0] md);
        return (ev && (ed == r)) || (mv && (md == r));
    endfunction

    // Hazard detection and issue qualification.
    always_comb begin
        haz = id_valid &&
              ((id_rs_used && match(id_rs, ex_v, ex_dst, mem_v, mem_dst)) ||
               (id_rt_used && match(id_rt, ex_v, ex_dst, mem_v, mem_dst)));
        issue = (state == RUN) && id_valid && !haz && !ex_branch_taken;
    end

    // Pipeline control outputs from state and current conditions.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_stall = 1'b0;
        halted     = 1'b0;
        case (state)
            RUN: begin
                idex_en = 1'b1;
                if (ex_branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_stall = 1'b1;
                end else if (haz) begin
                    idex_stall = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            DRAIN: begin
                idex_en    = 1'b1;
                idex_stall = 1'b1;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Run/drain/halt sequencing with the drain countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= RUN;
            drain_cnt <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (issue && id_halt) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd3;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Writer tracker advances whenever ID/EX loads (issue or bubble).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v    <= 1'b0;
            ex_dst  <= 3'd0;
            mem_v   <= 1'b0;
            mem_dst <= 3'd0;
        end else if (idex_en) begin
            ex_v    <= issue && id_wr;
            ex_dst  <= id_dst;
            mem_v   <= ex_v;
            mem_dst <= ex_dst;
        end
    end

    // Saturating count of data-hazard stall cycles in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if ((state == RUN) && !ex_branch_taken && haz &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
